// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes on request and result.
//   Keeps the 6-bit opcode map and {C,S,V,Z} flags of the original 16-bit
//   combinational ALU. Adds:
//   - carry-in arithmetic (ADC/SBC)
//   - a true signed-overflow flag
//   - variable-count shifts, one bit per cycle
//   - a shift-add multiply, one multiplier bit per cycle
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_valid / o_ready         request handshake (o_ready high only in IDLE)
//   i_ctrl, i_data_a,         opcode, operands and carry-in,
//   i_data_b, i_carry         captured on accept
//   o_valid / i_ready         result handshake (o_valid high only in DONE)
//   o_data, o_flag            result and {C,S,V,Z}; held while o_valid=1
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [5:0]       i_ctrl,
   input  logic [WIDTH-1:0] i_data_a,
   input  logic [WIDTH-1:0] i_data_b,
   input  logic             i_carry,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic [3:0]       o_flag
);
   localparam int MSB = WIDTH - 1;

   localparam logic [5:0] OP_ADD  = 6'h0A, OP_SUB  = 6'h09, OP_INC  = 6'h1B, OP_DEC = 6'h08;
   localparam logic [5:0] OP_ADC  = 6'h0B, OP_SBC  = 6'h0D;
   localparam logic [5:0] OP_AND  = 6'h06, OP_OR   = 6'h12, OP_NOT  = 6'h14, OP_XOR = 6'h16;
   localparam logic [5:0] OP_SHL  = 6'h20, OP_SHR  = 6'h30, OP_SAL  = 6'h24, OP_SAR = 6'h34;
   localparam logic [5:0] OP_ROL  = 6'h22, OP_ROR  = 6'h32;
   localparam logic [5:0] OP_SHLN = 6'h28, OP_SHRN = 6'h38, OP_SARN = 6'h3C;
   localparam logic [5:0] OP_MUL  = 6'h0E;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [5:0]       op_q;
   logic [WIDTH-1:0] mcand_q;   // multiplicand for MUL
   logic [WIDTH-1:0] hi_q;      // upper product half (MUL)
   logic [WIDTH-1:0] lo_q;      // multiplier / low product (MUL), shift operand (xxxN)
   logic [CNT_W-1:0] cnt_q;     // remaining BUSY cycles minus one

   function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
      return (sa != sb) && (sr != sa);
   endfunction

   function automatic logic [3:0] pack(input logic [WIDTH-1:0] r, input logic c, input logic v);
      return {c, r[MSB], v, (r == '0)};
   endfunction

   // Single-cycle result, computed straight from the inputs at accept time.
   // The default (pass A, C=0, V=0) also covers unlisted opcodes and
   // variable shifts with a zero count.
   logic [WIDTH:0]   ea, eb, ecin, one, sum;
   logic [WIDTH-1:0] s_res;
   logic             s_c, s_v;

   assign ea   = {1'b0, i_data_a};
   assign eb   = {1'b0, i_data_b};
   assign ecin = {{WIDTH{1'b0}}, i_carry};
   assign one  = {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      s_res = i_data_a;
      s_c   = 1'b0;
      s_v   = 1'b0;
      sum   = '0;
      case (i_ctrl)
         OP_ADD: begin
            sum = ea + eb;
            s_res = sum[MSB:0]; s_c = sum[WIDTH];
            s_v = add_ovf(i_data_a[MSB], i_data_b[MSB], sum[MSB]);
         end
         OP_ADC: begin
            sum = ea + eb + ecin;
            s_res = sum[MSB:0]; s_c = sum[WIDTH];
            s_v = add_ovf(i_data_a[MSB], i_data_b[MSB], sum[MSB]);
         end
         OP_INC: begin
            sum = ea + one;
            s_res = sum[MSB:0]; s_c = sum[WIDTH];
            s_v = add_ovf(i_data_a[MSB], 1'b0, sum[MSB]);
         end
         // For subtraction bit WIDTH of the extended difference is the borrow.
         OP_SUB: begin
            sum = ea - eb;
            s_res = sum[MSB:0]; s_c = sum[WIDTH];
            s_v = sub_ovf(i_data_a[MSB], i_data_b[MSB], sum[MSB]);
         end
         OP_SBC: begin
            sum = ea - eb - ecin;
            s_res = sum[MSB:0]; s_c = sum[WIDTH];
            s_v = sub_ovf(i_data_a[MSB], i_data_b[MSB], sum[MSB]);
         end
         OP_DEC: begin
            sum = ea - one;
            s_res = sum[MSB:0]; s_c = sum[WIDTH];
            s_v = sub_ovf(i_data_a[MSB], 1'b0, sum[MSB]);
         end
         OP_AND: s_res = i_data_a & i_data_b;
         OP_OR:  s_res = i_data_a | i_data_b;
         OP_NOT: s_res = ~i_data_a;
         OP_XOR: s_res = i_data_a ^ i_data_b;
         OP_SHL, OP_SAL: begin
            s_res = {i_data_a[MSB-1:0], 1'b0}; s_c = i_data_a[MSB];
         end
         OP_SHR: begin
            s_res = {1'b0, i_data_a[MSB:1]}; s_c = i_data_a[0];
         end
         OP_SAR: begin
            s_res = {i_data_a[MSB], i_data_a[MSB:1]}; s_c = i_data_a[0];
         end
         OP_ROL: begin
            s_res = {i_data_a[MSB-1:0], i_data_a[MSB]}; s_c = i_data_a[MSB];
         end
         OP_ROR: begin
            s_res = {i_data_a[0], i_data_a[MSB:1]}; s_c = i_data_a[0];
         end
         default: ;
      endcase
   end

   // One step of a variable-count shift; C tracks the bit just shifted out.
   logic [WIDTH-1:0] sh_n;
   logic             sh_c;

   always_comb begin
      case (op_q)
         OP_SHLN: begin sh_n = {lo_q[MSB-1:0], 1'b0};   sh_c = lo_q[MSB]; end
         OP_SHRN: begin sh_n = {1'b0, lo_q[MSB:1]};     sh_c = lo_q[0];   end
         default: begin sh_n = {lo_q[MSB], lo_q[MSB:1]}; sh_c = lo_q[0];  end
      endcase
   end

   // One shift-add multiply step: conditionally add the multiplicand into the
   // upper half, then shift the whole {carry, hi, lo} right by one. After
   // WIDTH steps {hi, lo} is the full 2*WIDTH-bit product.
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_n, mul_lo_n;

   assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
   assign mul_hi_n = mul_sum[WIDTH:1];
   assign mul_lo_n = {mul_sum[0], lo_q[MSB:1]};

   logic [CNT_W-1:0] shift_cnt;
   logic             is_shn;

   assign shift_cnt = i_data_b[CNT_W-1:0];
   assign is_shn    = (i_ctrl == OP_SHLN) || (i_ctrl == OP_SHRN) || (i_ctrl == OP_SARN);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         o_ready <= 1'b1;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_flag  <= '0;
         op_q    <= '0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
      end else begin
         case (state)
            IDLE: if (i_valid) begin
               op_q    <= i_ctrl;
               mcand_q <= i_data_a;
               if (is_shn && shift_cnt != '0) begin
                  lo_q    <= i_data_a;
                  cnt_q   <= shift_cnt - CNT_W'(1);
                  state   <= BUSY;
                  o_ready <= 1'b0;
               end else if (i_ctrl == OP_MUL) begin
                  lo_q    <= i_data_b;
                  hi_q    <= '0;
                  cnt_q   <= CNT_W'(WIDTH - 1);
                  state   <= BUSY;
                  o_ready <= 1'b0;
               end else begin
                  o_data  <= s_res;
                  o_flag  <= pack(s_res, s_c, s_v);
                  state   <= DONE;
                  o_valid <= 1'b1;
                  o_ready <= 1'b0;
               end
            end
            BUSY: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (op_q == OP_MUL) begin
                  hi_q <= mul_hi_n;
                  lo_q <= mul_lo_n;
                  if (cnt_q == '0) begin
                     o_data  <= mul_lo_n;
                     o_flag  <= pack(mul_lo_n, |mul_hi_n, 1'b0);
                     state   <= DONE;
                     o_valid <= 1'b1;
                  end
               end else begin
                  lo_q <= sh_n;
                  if (cnt_q == '0) begin
                     o_data  <= sh_n;
                     o_flag  <= pack(sh_n, sh_c, 1'b0);
                     state   <= DONE;
                     o_valid <= 1'b1;
                  end
               end
            end
            DONE: if (i_ready) begin
               state   <= IDLE;
               o_valid <= 1'b0;
               o_ready <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               o_valid <= 1'b0;
               o_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule
